// File: rtl/switch_control_rr_pkg.sv
// Shared constants, port indices, routing algorithm codes and controller
// state type for the Phoenix switch controller.
package switch_control_rr_pkg;

  localparam int unsigned TAM_FLIT   = 16;
  localparam int unsigned METADEFLIT = TAM_FLIT / 2;
  localparam int unsigned NPORT      = 5;
  localparam int unsigned PIDX_W     = 3;

  localparam int unsigned EAST  = 0;
  localparam int unsigned WEST  = 1;
  localparam int unsigned NORTH = 2;
  localparam int unsigned SOUTH = 3;
  localparam int unsigned LOCAL = 4;

  localparam int unsigned ALGO_XY = 0;
  localparam int unsigned ALGO_YX = 1;
  localparam int unsigned ALGO_WF = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_ROUTE,
    S_GRANT
  } state_t;

  function automatic logic [NPORT-1:0] port_onehot(input logic [PIDX_W-1:0] idx);
    port_onehot      = '0;
    port_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/switch_control_rr_route_calc.sv
// Combinational route computation: builds the candidate output set for the
// selected algorithm and returns the first free candidate as a one-hot target.
module route_calc
  import switch_control_rr_pkg::*;
#(
  parameter int unsigned        FLIT_W  = TAM_FLIT,
  parameter logic [FLIT_W-1:0]  ADDRESS = 'h0101,
  parameter int unsigned        ALGO    = ALGO_XY
) (
  input  logic [FLIT_W-1:0] dest,
  input  logic [NPORT-1:0]  out_busy,
  output logic [NPORT-1:0]  target,
  output logic              valid
);

  localparam int unsigned       CW = FLIT_W / 2;
  localparam logic [CW-1:0]     LX = ADDRESS[FLIT_W-1:CW];
  localparam logic [CW-1:0]     LY = ADDRESS[CW-1:0];

  logic [CW-1:0]    w_dx;
  logic [CW-1:0]    w_dy;
  logic             w_east;
  logic             w_west;
  logic             w_north;
  logic             w_south;
  logic [NPORT-1:0] w_cand;
  logic [NPORT-1:0] w_free;

  assign w_dx    = dest[FLIT_W-1:CW];
  assign w_dy    = dest[CW-1:0];
  assign w_east  = w_dx > LX;
  assign w_west  = w_dx < LX;
  assign w_north = w_dy > LY;
  assign w_south = w_dy < LY;

  always_comb begin
    w_cand = '0;
    if (ALGO == ALGO_WF) begin
      if (w_west) begin
        w_cand[WEST] = 1'b1;
      end else if (!(w_east || w_north || w_south)) begin
        w_cand[LOCAL] = 1'b1;
      end else begin
        w_cand[EAST]  = w_east;
        w_cand[NORTH] = w_north;
        w_cand[SOUTH] = w_south;
      end
    end else if (ALGO == ALGO_YX) begin
      if (w_south)      w_cand[SOUTH] = 1'b1;
      else if (w_north) w_cand[NORTH] = 1'b1;
      else if (w_east)  w_cand[EAST]  = 1'b1;
      else if (w_west)  w_cand[WEST]  = 1'b1;
      else              w_cand[LOCAL] = 1'b1;
    end else begin
      if (w_east)       w_cand[EAST]  = 1'b1;
      else if (w_west)  w_cand[WEST]  = 1'b1;
      else if (w_south) w_cand[SOUTH] = 1'b1;
      else if (w_north) w_cand[NORTH] = 1'b1;
      else              w_cand[LOCAL] = 1'b1;
    end
  end

  // XY/YX yield a single candidate, so the E,N,S priority only matters for west-first
  always_comb begin
    w_free = w_cand & ~out_busy;
    target = '0;
    if (w_free[EAST])       target[EAST]  = 1'b1;
    else if (w_free[NORTH]) target[NORTH] = 1'b1;
    else if (w_free[SOUTH]) target[SOUTH] = 1'b1;
    else if (w_free[WEST])  target[WEST]  = 1'b1;
    else if (w_free[LOCAL]) target[LOCAL] = 1'b1;
    valid = |w_free;
  end

endmodule

// File: rtl/switch_control_rr.sv
// Phoenix NoC switch controller: round-robin header arbitration, route
// computation and output allocation held until the owning input releases.
module switch_control_rr
  import switch_control_rr_pkg::*;
#(
  parameter int unsigned       FLIT_W  = TAM_FLIT,
  parameter logic [FLIT_W-1:0] ADDRESS = 'h0101,
  parameter int unsigned       ALGO    = ALGO_XY
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NPORT-1:0]          h,
  input  logic [NPORT*FLIT_W-1:0]   data_in,
  input  logic [NPORT-1:0]          release_in,
  output logic [NPORT-1:0]          ack_h,
  output logic [NPORT-1:0]          out_busy,
  output logic [NPORT*PIDX_W-1:0]   out_src,
  output logic [NPORT-1:0]          in_busy
);

  state_t              r_state;
  state_t              w_next;
  logic [PIDX_W-1:0]   r_last;
  logic [PIDX_W-1:0]   r_sel;
  logic [FLIT_W-1:0]   r_dest;
  logic [NPORT-1:0]    r_target;
  logic [NPORT-1:0]    r_out_busy;
  logic [NPORT-1:0]    r_in_busy;
  logic [PIDX_W-1:0]   r_out_src [NPORT];

  logic [NPORT-1:0]    w_elig;
  logic [PIDX_W-1:0]   w_scan;
  logic [PIDX_W-1:0]   w_arb_sel;
  logic                w_arb_found;
  logic [NPORT-1:0]    w_rt_target;
  logic                w_rt_valid;

  assign w_elig = h & ~r_in_busy;

  always_comb begin
    w_arb_found = 1'b0;
    w_arb_sel   = '0;
    w_scan      = '0;
    for (int unsigned k = 1; k <= NPORT; k++) begin
      w_scan = PIDX_W'((32'(r_last) + k) % NPORT);
      if (!w_arb_found && w_elig[w_scan]) begin
        w_arb_found = 1'b1;
        w_arb_sel   = w_scan;
      end
    end
  end

  route_calc #(
    .FLIT_W  (FLIT_W),
    .ADDRESS (ADDRESS),
    .ALGO    (ALGO)
  ) u_route (
    .dest     (r_dest),
    .out_busy (r_out_busy),
    .target   (w_rt_target),
    .valid    (w_rt_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    ack_h  = '0;
    case (r_state)
      S_IDLE:  if (|w_elig) w_next = S_ARB;
      S_ARB:   w_next = w_arb_found ? S_ROUTE : S_IDLE;
      S_ROUTE: w_next = w_rt_valid ? S_GRANT : S_IDLE;
      S_GRANT: begin
        ack_h  = port_onehot(r_sel);
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Releases are applied before the grant so a grant always wins on shared
  // bits; the target was chosen from pre-release busy flags, so no output
  // can be released and granted together.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last     <= PIDX_W'(LOCAL);
      r_sel      <= '0;
      r_dest     <= '0;
      r_target   <= '0;
      r_out_busy <= '0;
      r_in_busy  <= '0;
      for (int unsigned o = 0; o < NPORT; o++) r_out_src[o] <= '0;
    end else begin
      for (int unsigned o = 0; o < NPORT; o++) begin
        if (r_out_busy[o] && release_in[r_out_src[o]] && r_in_busy[r_out_src[o]])
          r_out_busy[o] <= 1'b0;
      end
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (release_in[i]) r_in_busy[i] <= 1'b0;
      end
      if (r_state == S_ARB && w_arb_found) begin
        r_sel  <= w_arb_sel;
        r_last <= w_arb_sel;
        r_dest <= data_in[w_arb_sel*FLIT_W +: FLIT_W];
      end
      if (r_state == S_ROUTE) r_target <= w_rt_target;
      if (r_state == S_GRANT) begin
        for (int unsigned o = 0; o < NPORT; o++) begin
          if (r_target[o]) begin
            r_out_busy[o] <= 1'b1;
            r_out_src[o]  <= r_sel;
          end
        end
        r_in_busy[r_sel] <= 1'b1;
      end
    end
  end

  assign out_busy = r_out_busy;
  assign in_busy  = r_in_busy;

  always_comb begin
    out_src = '0;
    for (int unsigned o = 0; o < NPORT; o++) out_src[o*PIDX_W +: PIDX_W] = r_out_src[o];
  end

endmodule

// File: tb/tb_switch_control_rr.sv
// Bench for switch_control_rr: three instances (XY, YX, west-first) share
// stimulus; directed scenarios plus random traffic against a reference model.
module tb_switch_control_rr;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [4:0]        h     = '0;
  logic [4:0]        rel   = '0;
  logic [79:0]       data_in = '0;
  logic [2:0][4:0]   ack;
  logic [2:0][4:0]   ob;
  logic [2:0][4:0]   ib;
  logic [2:0][14:0]  os;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  switch_control_rr #(.FLIT_W(16), .ADDRESS(16'h0101), .ALGO(0)) u_xy (
    .clock(clock), .reset(reset), .h(h), .data_in(data_in), .release_in(rel),
    .ack_h(ack[0]), .out_busy(ob[0]), .out_src(os[0]), .in_busy(ib[0]));
  switch_control_rr #(.FLIT_W(16), .ADDRESS(16'h0101), .ALGO(1)) u_yx (
    .clock(clock), .reset(reset), .h(h), .data_in(data_in), .release_in(rel),
    .ack_h(ack[1]), .out_busy(ob[1]), .out_src(os[1]), .in_busy(ib[1]));
  switch_control_rr #(.FLIT_W(16), .ADDRESS(16'h0101), .ALGO(2)) u_wf (
    .clock(clock), .reset(reset), .h(h), .data_in(data_in), .release_in(rel),
    .ack_h(ack[2]), .out_busy(ob[2]), .out_src(os[2]), .in_busy(ib[2]));

  // Reference routing from coordinate differences; -1 means no free target.
  function automatic int ref_route(int algo, logic [15:0] d, logic [4:0] busy);
    int ex, ey, res;
    int cand[$];
    ex = int'(d[15:8]) - 1;
    ey = int'(d[7:0]) - 1;
    if (algo == 2) begin
      if (ex < 0) cand.push_back(1);
      else begin
        if (ex > 0) cand.push_back(0);
        if (ey > 0) cand.push_back(2);
        if (ey < 0) cand.push_back(3);
        if (cand.size() == 0) cand.push_back(4);
      end
    end else if (algo == 1) begin
      cand.push_back(ey < 0 ? 3 : ey > 0 ? 2 : ex > 0 ? 0 : ex < 0 ? 1 : 4);
    end else begin
      cand.push_back(ex > 0 ? 0 : ex < 0 ? 1 : ey < 0 ? 3 : ey > 0 ? 2 : 4);
    end
    res = -1;
    foreach (cand[k]) if (res < 0 && !busy[cand[k]]) res = cand[k];
    return res;
  endfunction

  // Cycle-level reference: phase counts progress of the current arbitration
  // (0 waiting, 1 picking, 2 routing, 3 acknowledging).
  logic [4:0]  m_ob [3];
  logic [4:0]  m_ib [3];
  logic [2:0]  m_src [3][5];
  logic [15:0] m_dest [3];
  int          m_ph [3];
  int          m_last [3];
  int          m_sel [3];
  int          m_tgt [3];

  always @(posedge clock) begin : model
    logic [4:0] ob0, ib0;
    int found, idx, t;
    for (int a = 0; a < 3; a++) begin
      if (reset) begin
        m_ob[a] = '0; m_ib[a] = '0; m_ph[a] = 0; m_last[a] = 4; m_sel[a] = 0;
        for (int o = 0; o < 5; o++) m_src[a][o] = '0;
      end else begin
        ob0 = m_ob[a];
        ib0 = m_ib[a];
        for (int i = 0; i < 5; i++) begin
          if (rel[i] && ib0[i]) begin
            m_ib[a][i] = 1'b0;
            for (int o = 0; o < 5; o++)
              if (ob0[o] && m_src[a][o] == 3'(i)) m_ob[a][o] = 1'b0;
          end
        end
        case (m_ph[a])
          0: if ((h & ~ib0) != 0) m_ph[a] = 1;
          1: begin
            found = -1;
            for (int k = 1; k <= 5; k++) begin
              idx = (m_last[a] + k) % 5;
              if (found < 0 && h[idx] && !ib0[idx]) found = idx;
            end
            if (found < 0) m_ph[a] = 0;
            else begin
              m_sel[a]  = found;
              m_last[a] = found;
              m_dest[a] = data_in[found*16 +: 16];
              m_ph[a]   = 2;
            end
          end
          2: begin
            t = ref_route(a, m_dest[a], ob0);
            if (t < 0) m_ph[a] = 0;
            else begin m_tgt[a] = t; m_ph[a] = 3; end
          end
          default: begin
            m_ob[a][m_tgt[a]] = 1'b1;
            m_src[a][m_tgt[a]] = 3'(m_sel[a]);
            m_ib[a][m_sel[a]] = 1'b1;
            m_ph[a] = 0;
          end
        endcase
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; h = '0; rel = '0; data_in = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_dest(input int i, input logic [15:0] d);
    data_in[i*16 +: 16] = d;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; h = '0; rel = '0;
    repeat (2) @(negedge clock);
    for (int a = 0; a < 3; a++) begin
      n_tests++;
      if (ack[a] !== 5'b0 || ob[a] !== 5'b0 || ib[a] !== 5'b0 || os[a] !== 15'b0) begin
        n_fail++;
        $display("FAIL reset inst=%0d got ack=%b ob=%b ib=%b os=%h exp all zero", a, ack[a], ob[a], ib[a], os[a]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int cyc; bit got;
    do_reset();
    set_dest(4, 16'h0301); h = 5'b10000;
    cyc = 0; got = 0;
    while (!got && cyc < 10) begin @(negedge clock); cyc++; if (ack[0] != 0) got = 1; end
    n_tests++;
    if (!got || cyc != 3 || ack[0] !== 5'b10000) begin
      n_fail++;
      $display("FAIL single_ack got ack=%b after %0d cycles exp 10000 after 3", ack[0], cyc);
    end
    h = '0;
    @(negedge clock);
    n_tests++;
    if (ob[0] !== 5'b00001 || os[0][2:0] !== 3'd4 || ib[0] !== 5'b10000) begin
      n_fail++;
      $display("FAIL single_alloc got ob=%b src0=%0d ib=%b exp 00001 4 10000", ob[0], os[0][2:0], ib[0]);
    end
    rel = 5'b10000;
    @(negedge clock);
    rel = '0;
    n_tests++;
    if (ob[0] !== 5'b0 || ib[0] !== 5'b0) begin
      n_fail++;
      $display("FAIL single_release got ob=%b ib=%b exp 00000 00000", ob[0], ib[0]);
    end
  endtask

  task automatic test_fairness();
    int cyc; bit got;
    do_reset();
    set_dest(0, 16'h0301); set_dest(1, 16'h0001); set_dest(2, 16'h0103);
    set_dest(3, 16'h0100); set_dest(4, 16'h0101);
    h = 5'b11111;
    for (int k = 0; k < 5; k++) begin
      cyc = 0; got = 0;
      while (!got && cyc < 10) begin @(negedge clock); cyc++; if (ack[0] != 0) got = 1; end
      n_tests++;
      if (!got || cyc != (k == 0 ? 3 : 4) || ack[0] !== 5'(1 << k) || ack[1] !== ack[0] || ack[2] !== ack[0]) begin
        n_fail++;
        $display("FAIL fair_grant%0d got ack=%b/%b/%b after %0d exp %b after %0d",
                 k, ack[0], ack[1], ack[2], cyc, 5'(1 << k), (k == 0 ? 3 : 4));
      end
      h[k] = 1'b0;
    end
    @(negedge clock);
    for (int a = 0; a < 3; a++) begin
      n_tests++;
      if (ob[a] !== 5'b11111 || ib[a] !== 5'b11111 || os[a] !== {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}) begin
        n_fail++;
        $display("FAIL fair_alloc inst=%0d got ob=%b ib=%b os=%h exp 11111 11111 %h",
                 a, ob[a], ib[a], os[a], {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
      end
    end
    rel = 5'b11111;
    @(negedge clock);
    rel = '0;
    n_tests++;
    if (ob[0] !== 5'b0 || ob[1] !== 5'b0 || ob[2] !== 5'b0) begin
      n_fail++;
      $display("FAIL fair_release got ob=%b/%b/%b exp all 00000", ob[0], ob[1], ob[2]);
    end
  endtask

  task automatic test_blocking();
    int cyc; bit got, seen;
    do_reset();
    set_dest(1, 16'h0301); h = 5'b00010;
    cyc = 0; got = 0;
    while (!got && cyc < 10) begin @(negedge clock); cyc++; if (ack[0] != 0) got = 1; end
    n_tests++;
    if (!got || ack[0] !== 5'b00010) begin
      n_fail++;
      $display("FAIL block_first got ack=%b exp 00010", ack[0]);
    end
    h = 5'b10000; set_dest(4, 16'h0301);
    seen = 0;
    repeat (12) begin @(negedge clock); if (ack[0] != 0) seen = 1; end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL block_hold got an ack while EAST busy exp none");
    end
    rel = 5'b00010;
    @(negedge clock);
    rel = '0;
    cyc = 1; got = (ack[0] != 0);
    while (!got && cyc < 10) begin @(negedge clock); cyc++; if (ack[0] != 0) got = 1; end
    n_tests++;
    if (!got || cyc > 7 || ack[0] !== 5'b10000) begin
      n_fail++;
      $display("FAIL block_unblock got ack=%b after %0d cycles exp 10000 within 7", ack[0], cyc);
    end
    h = '0;
    @(negedge clock);
    n_tests++;
    if (ob[0] !== 5'b00001 || os[0][2:0] !== 3'd4) begin
      n_fail++;
      $display("FAIL block_alloc got ob=%b src0=%0d exp 00001 4", ob[0], os[0][2:0]);
    end
  endtask

  task automatic test_algos();
    int cyc; bit got;
    do_reset();
    set_dest(0, 16'h0300); h = 5'b00001;
    cyc = 0; got = 0;
    while (!got && cyc < 10) begin @(negedge clock); cyc++; if (ack[0] != 0) got = 1; end
    h = '0;
    @(negedge clock);
    n_tests++;
    if (!got || ob[0] !== 5'b00001 || ob[1] !== 5'b01000 || ob[2] !== 5'b00001 || os[1][9 +: 3] !== 3'd0) begin
      n_fail++;
      $display("FAIL algo_0300 got ob=%b/%b/%b exp 00001/01000/00001", ob[0], ob[1], ob[2]);
    end
    do_reset();
    set_dest(0, 16'h0101); h = 5'b00001;
    cyc = 0; got = 0;
    while (!got && cyc < 10) begin @(negedge clock); cyc++; if (ack[0] != 0) got = 1; end
    h = '0;
    @(negedge clock);
    n_tests++;
    if (!got || ob[0] !== 5'b10000 || ob[1] !== 5'b10000 || ob[2] !== 5'b10000) begin
      n_fail++;
      $display("FAIL algo_local got ob=%b/%b/%b exp 10000 in all", ob[0], ob[1], ob[2]);
    end
  endtask

  task automatic test_west_first();
    int cyc; bit got, seen;
    do_reset();
    set_dest(1, 16'h0301); h = 5'b00010;
    cyc = 0; got = 0;
    while (!got && cyc < 10) begin @(negedge clock); cyc++; if (ack[2] != 0) got = 1; end
    set_dest(0, 16'h0302); h = 5'b00001;
    cyc = 0; got = 0;
    while (!got && cyc < 10) begin @(negedge clock); cyc++; if (ack[2] != 0) got = 1; end
    n_tests++;
    if (!got || ack[2] !== 5'b00001) begin
      n_fail++;
      $display("FAIL wf_ack got ack=%b exp 00001", ack[2]);
    end
    h = '0;
    @(negedge clock);
    n_tests++;
    if (ob[2] !== 5'b00101 || os[2][6 +: 3] !== 3'd0) begin
      n_fail++;
      $display("FAIL wf_north got ob=%b srcN=%0d exp 00101 0", ob[2], os[2][6 +: 3]);
    end
    set_dest(3, 16'h0302); h = 5'b01000;
    seen = 0;
    repeat (12) begin @(negedge clock); if (ack[2] != 0) seen = 1; end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL wf_blocked got an ack with EAST and NORTH busy exp none");
    end
    rel = 5'b00010;
    @(negedge clock);
    rel = '0;
    cyc = 1; got = (ack[2] != 0);
    while (!got && cyc < 10) begin @(negedge clock); cyc++; if (ack[2] != 0) got = 1; end
    h = '0;
    @(negedge clock);
    n_tests++;
    if (!got || ob[2] !== 5'b00101 || os[2][2:0] !== 3'd3) begin
      n_fail++;
      $display("FAIL wf_retry got ob=%b srcE=%0d exp 00101 3", ob[2], os[2][2:0]);
    end
    do_reset();
    set_dest(2, 16'h0002); h = 5'b00100;
    cyc = 0; got = 0;
    while (!got && cyc < 10) begin @(negedge clock); cyc++; if (ack[2] != 0) got = 1; end
    h = '0;
    @(negedge clock);
    n_tests++;
    if (!got || ob[2] !== 5'b00010 || os[2][3 +: 3] !== 3'd2) begin
      n_fail++;
      $display("FAIL wf_west got ob=%b srcW=%0d exp 00010 2", ob[2], os[2][3 +: 3]);
    end
  endtask

  task automatic test_reset_grant();
    int cyc; bit got;
    do_reset();
    set_dest(0, 16'h0301); h = 5'b00001;
    cyc = 0; got = 0;
    while (!got && cyc < 10) begin @(negedge clock); cyc++; if (ack[0] != 0) got = 1; end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_tests++;
    if (!got || ack[0] !== 5'b0 || ob[0] !== 5'b0 || ib[0] !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_grant got ack=%b ob=%b ib=%b exp all zero", ack[0], ob[0], ib[0]);
    end
    cyc = 0; got = 0;
    while (!got && cyc < 10) begin @(negedge clock); cyc++; if (ack[0] != 0) got = 1; end
    n_tests++;
    if (!got || cyc != 3 || ack[0] !== 5'b00001) begin
      n_fail++;
      $display("FAIL rst_regrant got ack=%b after %0d cycles exp 00001 after 3", ack[0], cyc);
    end
    h = '0;
    @(negedge clock);
    n_tests++;
    if (ob[0] !== 5'b00001) begin
      n_fail++;
      $display("FAIL rst_alloc got ob=%b exp 00001", ob[0]);
    end
  endtask

  task automatic test_random();
    logic [4:0]  exp_ack;
    logic [14:0] exp_os, act_os;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      for (int a = 0; a < 3; a++) begin
        exp_ack = (m_ph[a] == 3) ? 5'(1 << m_sel[a]) : 5'b0;
        exp_os = '0; act_os = '0;
        for (int o = 0; o < 5; o++) begin
          if (m_ob[a][o]) begin
            exp_os[o*3 +: 3] = m_src[a][o];
            act_os[o*3 +: 3] = os[a][o*3 +: 3];
          end
        end
        n_tests++;
        if (ack[a] !== exp_ack) begin
          n_fail++;
          $display("FAIL rand_ack inst=%0d cyc=%0d got=%b exp=%b", a, c, ack[a], exp_ack);
        end
        n_tests++;
        if (ob[a] !== m_ob[a] || ib[a] !== m_ib[a]) begin
          n_fail++;
          $display("FAIL rand_busy inst=%0d cyc=%0d got ob=%b ib=%b exp ob=%b ib=%b", a, c, ob[a], ib[a], m_ob[a], m_ib[a]);
        end
        n_tests++;
        if (act_os !== exp_os) begin
          n_fail++;
          $display("FAIL rand_src inst=%0d cyc=%0d got=%h exp=%h", a, c, act_os, exp_os);
        end
        n_tests++;
        if ($countones(ob[a]) != $countones(ib[a])) begin
          n_fail++;
          $display("FAIL rand_count inst=%0d cyc=%0d got ob=%b ib=%b exp equal popcounts", a, c, ob[a], ib[a]);
        end
      end
      reset = ($urandom_range(0, 149) == 0);
      h = 5'($urandom);
      for (int i = 0; i < 5; i++) begin
        rel[i] = ($urandom_range(0, 5) == 0);
        data_in[i*16 +: 16] = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
      end
    end
    reset = 1'b0; h = '0; rel = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_blocking();
    test_algos();
    test_west_first();
    test_reset_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
